// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state encoding and default width for the bit-serial adder
package serial_adder_pkg;
  localparam int DEF_WIDTH = 16;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/serial_rca_adder_fulladder.sv
// fulladder: single-bit gate-level full adder slice
// ports: a, b, ci in; s = a^b^ci, co = majority(a, b, ci) out
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic p;
  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);
endmodule

// File: rtl/serial_rca_adder.sv
// serial_rca_adder: bit-serial WIDTH-bit adder, one full-adder slice per clock, start/done handshake
// ports: clk, rst (async high), start, a, b, cin, sub (SERIAL_ADD_SUB_EN only) in;
//        busy, done (1-cycle pulse), sum, cout, overflow out
// optional feature macro: SERIAL_ADD_SUB_EN adds the sub port for a-b
import serial_adder_pkg::*;
module serial_rca_adder #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] s_sh;
  logic [WIDTH-1:0] s_nxt;
  logic [CW-1:0]    count;
  logic             carry, fa_s, fa_co;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;
`ifdef SERIAL_ADD_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub | cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif
  fulladder u_fa (.a(a_sh[0]), .b(b_sh[0]), .ci(carry), .s(fa_s), .co(fa_co));
  // s_sh holds only the upper WIDTH-1 bits of the partial sum; the newest bit enters at the top
  assign s_nxt = {fa_s, s_sh};
  assign busy  = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      s_sh     <= '0;
      count    <= '0;
      carry    <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_sh  <= a;
          b_sh  <= b_ld;
          carry <= c_ld;
          count <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          s_sh  <= s_nxt[WIDTH-1:1];
          carry <= fa_co;
          count <= count + CW'(1);
          if (count == LAST) begin
            sum      <= s_nxt;
            cout     <= fa_co;
            overflow <= carry ^ fa_co;
            done     <= 1'b1;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_rca_adder.sv
// tb_serial_rca_adder: directed self-checking bench for serial_rca_adder (WIDTH=16)
module tb_serial_rca_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
  logic        sub = 1'b0;
`endif
  logic        busy, done, cout, overflow;
  logic [15:0] sum;
  int          passed = 0, total = 0;
  serial_rca_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub(sub),
`endif
    .busy(busy), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    #12;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
    total++; if (sum !== 16'h0) $display("FAIL reset_sum got %h want 0000", sum); else passed++;
    total++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else passed++;
    @(negedge clk); rst = 1'b0;
  endtask
  task automatic test_add(input string nm, input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tc, input logic [15:0] es, input logic ec, input logic eo);
    int n = 0;
    start_op(ta, tb_v, tc);
    total++; if (busy !== 1'b1) $display("FAIL %s_busy_after_accept got %b want 1", nm, busy); else passed++;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    total++; if (n !== 16) $display("FAIL %s_latency got %0d want 16", nm, n); else passed++;
    total++; if (sum !== es) $display("FAIL %s_sum got %h want %h", nm, sum, es); else passed++;
    total++; if (cout !== ec) $display("FAIL %s_cout got %b want %b", nm, cout, ec); else passed++;
    total++; if (overflow !== eo) $display("FAIL %s_ovf got %b want %b", nm, overflow, eo); else passed++;
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL %s_pulse_end got done=%b busy=%b want 0 0", nm, done, busy); else passed++;
  endtask
  task automatic test_back_to_back;
    int nb = 0;
    logic [15:0] got = 16'hdead;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      a = (i == 0) ? 16'h1234 : 16'h0f0f + 16'(i);
      b = (i == 0) ? 16'h1111 : 16'h7000;
      cin = (i != 0);
      start = 1'b1;
      @(posedge clk); #1;
      if (busy) nb++;
      if (done) got = sum;
    end
    @(negedge clk); start = 1'b0;
    total++; if (nb !== 17) $display("FAIL b2b_busy_cycles got %0d want 17", nb); else passed++;
    total++; if (got !== 16'h2345) $display("FAIL b2b_sum got %h want 2345", got); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL b2b_idle_after got %b want 0", busy); else passed++;
  endtask
  task automatic test_reset_mid;
    start_op(16'haaaa, 16'h5555, 1'b0);
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rstmid_ctrl got busy=%b done=%b want 0 0", busy, done); else passed++;
    total++; if (sum !== 16'h0 || cout !== 1'b0 || overflow !== 1'b0)
      $display("FAIL rstmid_out got sum=%h cout=%b ovf=%b want 0000 0 0", sum, cout, overflow); else passed++;
    @(negedge clk); rst = 1'b0;
    test_add("after_rst", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
  endtask
`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    sub = 1'b1;
    test_add("sub_5_7", 16'h0005, 16'h0007, 1'b0, 16'hfffe, 1'b0, 1'b0);
    test_add("sub_ovf", 16'h8000, 16'h0001, 1'b0, 16'h7fff, 1'b1, 1'b1);
    sub = 1'b0;
  endtask
`endif
  initial begin
    test_reset;
    test_add("one_one", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    test_add("wrap", 16'hffff, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    test_add("ovf_cin", 16'h7fff, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1);
    test_back_to_back;
    test_reset_mid;
`ifdef SERIAL_ADD_SUB_EN
    test_sub;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
